// File: rtl/ysyx_23060072_fetch_queue_pkg.sv
// Shared core definitions for the rv32e fetch path: word width, bubble encoding
// and the {pc, inst} fetch packet carried from IF to ID.
package ysyx_23060072_fetch_queue_pkg;

    localparam int unsigned XLEN = 32;

    // addi x0, x0, 0 -- inserted downstream as a pipeline bubble
    localparam logic [XLEN-1:0] NOP_INST = 32'h00000013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_pkt_t;

endpackage

// File: rtl/ysyx_23060072_sync_fifo.sv
// Generic DEPTH x WIDTH register-array FIFO with wrap-bit pointers, a synchronous
// clear and an occupancy count. DEPTH must be a power of two, at least 2.
module ysyx_23060072_sync_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     wr_en_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_en_i,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PtrW = $clog2(DEPTH) + 1;
    localparam int unsigned IdxW = PtrW - 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic             push, pop;

    // Extra MSB on each pointer tells a full queue apart from an empty one
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[IdxW-1:0] == rd_ptr_q[IdxW-1:0]) &&
                     (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]);
    assign push    = wr_en_i && !full_o;
    assign pop     = rd_en_i && !empty_o;

    assign rd_data_o = mem_q[rd_ptr_q[IdxW-1:0]];
    assign count_o   = wr_ptr_q - rd_ptr_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage is never cleared; stale contents are unreachable once pointers reset
    always_ff @(posedge clk_i) begin
        if (push && !clr_i && !rst_i) begin
            mem_q[wr_ptr_q[IdxW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/ysyx_23060072_fetch_queue.sv
// Instruction fetch queue between IF and ID: buffers {pc, inst} pairs, drops
// everything on a redirect flush and masks the head to zero while empty.
module ysyx_23060072_fetch_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = ysyx_23060072_fetch_queue_pkg::XLEN
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        in_pc,
    input  logic [XLEN-1:0]        in_inst,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [XLEN-1:0]        out_pc,
    output logic [XLEN-1:0]        out_inst,
    output logic [$clog2(DEPTH):0] count
);

    logic [2*XLEN-1:0] rd_data;
    logic              full;
    logic              empty;

    ysyx_23060072_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk_i     (clk),
        .rst_i     (rst),
        .clr_i     (flush),
        .wr_en_i   (in_valid),
        .wr_data_i ({in_pc, in_inst}),
        .rd_en_i   (out_ready),
        .full_o    (full),
        .empty_o   (empty),
        .rd_data_o (rd_data),
        .count_o   (count)
    );

    // Ready depends only on state so IF never sees a path from ID's out_ready
    assign in_ready  = !full;
    assign out_valid = !empty;

    always_comb begin
        out_pc   = '0;
        out_inst = '0;
        if (!empty) begin
            {out_pc, out_inst} = rd_data;
        end
    end

endmodule

// File: tb/tb_ysyx_23060072_fetch_queue.sv
// Self-checking bench for the fetch queue against a queue-based reference model.
module tb_ysyx_23060072_fetch_queue;
    import ysyx_23060072_fetch_queue_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    fetch_pkt_t mq[$];

    ysyx_23060072_fetch_queue #(
        .DEPTH (DEPTH),
        .XLEN  (32)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pc    (out_pc),
        .out_inst  (out_inst),
        .count     (count)
    );

    always #5 clk = ~clk;

    // Advance one clock, updating the model from the inputs seen at the edge
    task automatic tick();
        bit         do_push;
        bit         do_pop;
        fetch_pkt_t p;
        do_push = in_valid && (mq.size() < DEPTH);
        do_pop  = out_ready && (mq.size() > 0);
        p.pc    = in_pc;
        p.inst  = in_inst;
        @(posedge clk);
        if (rst || flush) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back(p);
        end
        #1;
    endtask

    task automatic idle_inputs();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    endtask

    task automatic push_one(input logic [31:0] pc, input logic [31:0] inst);
        in_valid = 1'b1; in_pc = pc; in_inst = inst;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        idle_inputs();
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || out_inst !== 32'h0)
            begin
                errors++;
                $display("FAIL reset_idle cyc=%0d: got valid=%b ready=%b count=%0d inst=%h, need 0 1 0 0",
                         i, out_valid, in_ready, count, out_inst);
            end
        end
    endtask

    task automatic test_single_push();
        push_one(32'h8000_0000, 32'h0010_0093);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h8000_0000 || out_inst !== 32'h0010_0093 ||
                count !== 3'd1) begin
                errors++;
                $display("FAIL single_push hold=%0d: got valid=%b pc=%h inst=%h count=%0d, need 1 80000000 00100093 1",
                         i, out_valid, out_pc, out_inst, count);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL single_pop: got count=%0d valid=%b pc=%h, need 0 0 0",
                     count, out_valid, out_pc);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) push_one(32'(i * 4), $urandom);
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: got ready=%b count=%0d, need 0 4", in_ready, count);
        end
        push_one(32'h10, 32'hdead_beef);
        checks++;
        if (count !== 3'd4 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL push_when_full: got count=%0d head=%h, need 4 0", count, out_pc);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_inst !== mq[0].inst) begin
                errors++;
                $display("FAIL drain_order idx=%0d: got valid=%b pc=%h inst=%h, need 1 %h %h",
                         i, out_valid, out_pc, out_inst, 32'(i * 4), mq[0].inst);
            end
            tick();
        end
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: got valid=%b count=%0d, need 0 0", out_valid, count);
        end
    endtask

    task automatic test_streaming();
        logic [31:0] base;
        base = 32'h0000_0200;
        in_valid = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            in_pc = base + 32'(4 * k);
            in_inst = $urandom;
            tick();
            checks++;
            if (count !== 3'd1 || out_valid !== 1'b1 || out_pc !== base + 32'(4 * k)) begin
                errors++;
                $display("FAIL stream cyc=%0d: got count=%0d valid=%b pc=%h, need 1 1 %h",
                         k, count, out_valid, out_pc, base + 32'(4 * k));
            end
        end
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        checks++;
        if (count !== 3'd0) begin
            errors++;
            $display("FAIL stream_drain: got count=%0d need 0", count);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) push_one(32'h30 + 32'(4 * i), $urandom);
        flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40; in_inst = $urandom; out_ready = 1'b1;
        tick();
        idle_inputs();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL flush_clear: got count=%0d valid=%b pc=%h, need 0 0 0",
                     count, out_valid, out_pc);
        end
        push_one(32'h100, 32'h0000_0013);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || count !== 3'd1) begin
            errors++;
            $display("FAIL flush_next: got valid=%b pc=%h count=%0d, need 1 100 1",
                     out_valid, out_pc, count);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        push_one(32'h600, $urandom);
        push_one(32'h604, $urandom);
        rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h500; in_inst = $urandom;
        tick();
        idle_inputs();
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got count=%0d valid=%b ready=%b, need 0 0 1",
                     count, out_valid, in_ready);
        end
        tick();
        checks++;
        if (count !== 3'd0 || out_pc !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_nostore: got count=%0d pc=%h, need 0 0", count, out_pc);
        end
    endtask

    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 39) == 0);
            rst       = ($urandom_range(0, 96) == 0);
            in_pc     = $urandom;
            in_inst   = $urandom;
            tick();
            exp_pc   = (mq.size() > 0) ? mq[0].pc : 32'h0;
            exp_inst = (mq.size() > 0) ? mq[0].inst : 32'h0;
            checks++;
            if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH) ||
                count !== 3'(mq.size()) || out_pc !== exp_pc || out_inst !== exp_inst) begin
                errors++;
                $display("FAIL random cyc=%0d: got v=%b r=%b c=%0d pc=%h inst=%h, need v=%b r=%b c=%0d pc=%h inst=%h",
                         i, out_valid, in_ready, count, out_pc, out_inst,
                         mq.size() > 0, mq.size() < DEPTH, mq.size(), exp_pc, exp_inst);
            end
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_fill();
        test_streaming();
        test_flush();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
